// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the pipeline stages, the arbiter and the unified memory.
// Pure wiring; no state and no latency of its own.
// Backpressure is carried by the req/ready pairs on each side and by mem_req/mem_ack toward memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic                dm_req;
  logic                dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_be;
  logic [DATA_W-1:0]   dm_rdata;
  logic                dm_ready;

  logic flush_f;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  logic stall_if;
  logic stall_mem;
  logic bus_err;

  // Arbiter view: it is the master of the memory port.
  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, flush_f, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output stall_if, stall_mem, bus_err
  );

  // Environment view: pipeline requesters plus the memory itself.
  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, flush_f, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data stages, data first, one transaction in flight.
// Latency: request seen in IDLE, earliest ready one cycle later in the ack cycle (combinational ready/rdata).
// Backpressure: requesters stall until their ready pulse; a timeout forces completion and sets bus_err.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              discard;
  logic              launch;
  logic              done;
  logic              timed_out;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, launch selection and same-cycle completion outputs.
  always_comb begin
    state_nxt     = state;
    launch        = 1'b0;
    done          = 1'b0;
    bus.dm_ready  = 1'b0;
    bus.dm_rdata  = '0;
    bus.if_ready  = 1'b0;
    bus.if_rdata  = '0;
    // A real ack in the limit cycle wins over the forced completion.
    timed_out     = (TIMEOUT != 0) && (wait_cnt == TO_VAL) && !bus.mem_ack;
    // Data access has priority; a fetch fills the request with a full-word read.
    if (bus.dm_req) begin
      req_we    = bus.dm_we;
      req_addr  = bus.dm_addr;
      req_wdata = bus.dm_wdata;
      req_be    = bus.dm_be;
    end else begin
      req_we    = 1'b0;
      req_addr  = bus.if_addr;
      req_wdata = '0;
      req_be    = '1;
    end
    case (state)
      IDLE: begin
        if (bus.dm_req) begin
          launch    = 1'b1;
          state_nxt = BUSY_DM;
        end else if (bus.if_req && !bus.flush_f) begin
          launch    = 1'b1;
          state_nxt = BUSY_IF;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ack || timed_out) begin
          done      = 1'b1;
          state_nxt = IDLE;
          if (!rst) begin
            bus.dm_ready = 1'b1;
            bus.dm_rdata = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      BUSY_IF: begin
        if (bus.mem_ack || timed_out) begin
          done      = 1'b1;
          state_nxt = IDLE;
          // A fetch made stale by a taken branch completes silently.
          if (!rst && !discard && !bus.flush_f) begin
            bus.if_ready = 1'b1;
            bus.if_rdata = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers, stale-fetch flag, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      discard       <= 1'b0;
      wait_cnt      <= '0;
      bus.bus_err   <= 1'b0;
    end else if (launch) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= req_we;
      bus.mem_addr  <= req_addr;
      bus.mem_wdata <= req_wdata;
      bus.mem_be    <= req_be;
      discard       <= 1'b0;
      wait_cnt      <= '0;
    end else if (done) begin
      bus.mem_req <= 1'b0;
      discard     <= 1'b0;
      if (timed_out) bus.bus_err <= 1'b1;
    end else if (state != IDLE) begin
      if (TIMEOUT != 0) wait_cnt <= wait_cnt + 1'b1;
      if (state == BUSY_IF && bus.flush_f) discard <= 1'b1;
    end
  end

  // Stalls drop in the ready cycle so the requester advances on that edge.
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized checks of the fetch/data memory arbiter with TIMEOUT=4.
// Expected results come from a transaction plan ordered by the data-first rule.
// The bench plays both pipeline requesters and the memory.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_dm;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          fl;
    logic [31:0] rd;
  } txn_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks for an IDLE cycle with the requests currently driven by the bench.
  task automatic idle_cycle(input string tag, input bit exp_sm, input bit exp_si);
    @(negedge clk);
    chk({tag, "_mreq"}, bus.mem_req, 0);
    chk({tag, "_dmrdy"}, bus.dm_ready, 0);
    chk({tag, "_ifrdy"}, bus.if_ready, 0);
    chk({tag, "_stall_mem"}, bus.stall_mem, exp_sm);
    chk({tag, "_stall_if"}, bus.stall_if, exp_si);
    tick();
  endtask

  // Play memory for one transaction: ack after t.lat BUSY cycles, optional flush at cycle t.fl.
  task automatic serve(input string tag, input txn_t t);
    bit flushed = 0;
    bit exp_dr;
    bit exp_ir;
    for (int c = 0; c <= t.lat; c++) begin
      bus.mem_ack   = (c == t.lat);
      bus.mem_rdata = (c == t.lat) ? t.rd : $urandom;
      bus.flush_f   = (c == t.fl);
      if (c == t.fl) flushed = 1;
      exp_dr = t.is_dm && (c == t.lat);
      exp_ir = !t.is_dm && (c == t.lat) && !flushed;
      @(negedge clk);
      chk({tag, "_mreq"}, bus.mem_req, 1);
      chk({tag, "_maddr"}, bus.mem_addr, t.addr);
      chk({tag, "_mwe"}, bus.mem_we, t.is_dm ? t.we : 1'b0);
      chk({tag, "_mbe"}, bus.mem_be, t.is_dm ? t.be : 4'hF);
      if (t.is_dm) chk({tag, "_mwdata"}, bus.mem_wdata, t.wdata);
      chk({tag, "_dmrdy"}, bus.dm_ready, exp_dr);
      chk({tag, "_dmrdata"}, bus.dm_rdata, exp_dr ? t.rd : 32'h0);
      chk({tag, "_ifrdy"}, bus.if_ready, exp_ir);
      chk({tag, "_ifrdata"}, bus.if_rdata, exp_ir ? t.rd : 32'h0);
      chk({tag, "_stall_mem"}, bus.stall_mem, bus.dm_req & ~exp_dr);
      chk({tag, "_stall_if"}, bus.stall_if, bus.if_req & ~exp_ir);
      tick();
    end
    bus.mem_ack = 1'b0;
    bus.flush_f = 1'b0;
  endtask

  function automatic txn_t mk(input bit is_dm, input logic [31:0] addr, input bit we,
                              input logic [31:0] wdata, input logic [3:0] be, input int lat,
                              input int fl, input logic [31:0] rd);
    txn_t t;
    t.is_dm = is_dm; t.addr = addr; t.we = we; t.wdata = wdata;
    t.be = be; t.lat = lat; t.fl = fl; t.rd = rd;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t q[$];
    txn_t t;
    bit   do_dm;
    bit   do_if;
    int   kind;
    int   lat;

    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0;
    bus.dm_wdata = '0; bus.dm_be = '0; bus.flush_f = 0; bus.mem_rdata = '0; bus.mem_ack = 0;

    // Reset state.
    tick();
    @(negedge clk);
    chk("rst_dmrdy", bus.dm_ready, 0);
    chk("rst_ifrdy", bus.if_ready, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mreq", bus.mem_req, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_mbe", bus.mem_be, 0);
    chk("rst_buserr", bus.bus_err, 0);
    chk("rst_stall_if", bus.stall_if, 0);
    tick();

    // Fetch only, ack two cycles after mem_req rises.
    bus.if_req = 1; bus.if_addr = 32'h100;
    idle_cycle("f_idle", 0, 1);
    serve("fetch", mk(0, 32'h100, 0, 0, 4'hF, 2, -1, 32'h0050_0093));
    bus.if_req = 0;

    // Conflict: data served first, fetch held stalled, then fetch.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h2000; bus.dm_be = 4'hF; bus.dm_wdata = 32'h0;
    bus.if_req = 1; bus.if_addr = 32'h104;
    idle_cycle("c_idle", 1, 1);
    serve("c_dm", mk(1, 32'h2000, 0, 0, 4'hF, 1, -1, 32'hCAFE_0001));
    bus.dm_req = 0;
    idle_cycle("c_gap", 0, 1);
    serve("c_if", mk(0, 32'h104, 0, 0, 4'hF, 0, -1, 32'h1234_5678));
    bus.if_req = 0;

    // Store with partial byte enables; ready lasts exactly one cycle.
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
    idle_cycle("s_idle", 1, 0);
    serve("store", mk(1, 32'h2004, 1, 32'hDEAD_BEEF, 4'b0011, 3, -1, 32'h0));
    bus.dm_req = 0; bus.dm_we = 0;
    idle_cycle("s_after", 0, 0);

    // Flush during a fetch in flight, then a stale request in IDLE, then a normal fetch.
    bus.if_req = 1; bus.if_addr = 32'h108;
    idle_cycle("fl_idle", 0, 1);
    serve("fl_if", mk(0, 32'h108, 0, 0, 4'hF, 1, 0, 32'hBAD0_0108));
    bus.if_addr = 32'h200; bus.flush_f = 1;
    idle_cycle("fl_stale", 0, 1);
    bus.flush_f = 0;
    idle_cycle("fl_nolaunch", 0, 1);
    serve("fl_next", mk(0, 32'h200, 0, 0, 4'hF, 2, -1, 32'h0000_0200));
    bus.if_req = 0;

    // Randomized traffic against the data-first transaction plan.
    for (int it = 0; it < 40; it++) begin
      kind  = $urandom_range(0, 2);
      do_dm = (kind != 1);
      do_if = (kind != 0);
      bus.dm_req = do_dm; bus.dm_we = $urandom_range(0, 1); bus.dm_addr = $urandom;
      bus.dm_wdata = $urandom; bus.dm_be = 4'($urandom_range(0, 15));
      bus.if_req = do_if; bus.if_addr = $urandom & 32'hFFFF_FFFC;
      q.delete();
      if (do_dm) begin
        lat = $urandom_range(0, 3);
        q.push_back(mk(1, bus.dm_addr, bus.dm_we, bus.dm_wdata, bus.dm_be, lat, -1, $urandom));
      end
      if (do_if) begin
        lat = $urandom_range(0, 3);
        q.push_back(mk(0, bus.if_addr, 0, 0, 4'hF, lat,
                       ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat) : -1, $urandom));
      end
      idle_cycle("r_idle", do_dm, do_if);
      while (q.size() > 0) begin
        t = q.pop_front();
        serve(t.is_dm ? "r_dm" : "r_if", t);
        if (t.is_dm) bus.dm_req = 0;
        else         bus.if_req = 0;
        if (q.size() > 0) idle_cycle("r_gap", 0, 1);
      end
    end

    // Timeout: no ack; forced completion after four BUSY cycles.
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h3000; bus.dm_be = 4'hF;
    idle_cycle("t_idle", 1, 0);
    for (int c = 0; c < 4; c++) begin
      bus.mem_rdata = $urandom | 32'h1;
      @(negedge clk);
      chk("t_wait_mreq", bus.mem_req, 1);
      chk("t_wait_dmrdy", bus.dm_ready, 0);
      chk("t_wait_stall", bus.stall_mem, 1);
      chk("t_wait_buserr", bus.bus_err, 0);
      tick();
    end
    bus.mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t_fire_dmrdy", bus.dm_ready, 1);
    chk("t_fire_dmrdata", bus.dm_rdata, 0);
    chk("t_fire_stall", bus.stall_mem, 0);
    tick();
    bus.dm_req = 0;
    @(negedge clk);
    chk("t_after_mreq", bus.mem_req, 0);
    chk("t_after_buserr", bus.bus_err, 1);
    tick();
    tick();
    @(negedge clk);
    chk("t_sticky_buserr", bus.bus_err, 1);
    tick();

    // Reset in the middle of a data transaction; late ack is ignored.
    bus.dm_req = 1; bus.dm_addr = 32'h4000;
    idle_cycle("rm_idle", 1, 0);
    @(negedge clk);
    chk("rm_busy_mreq", bus.mem_req, 1);
    tick();
    rst = 1; bus.mem_ack = 1; bus.mem_rdata = 32'h1234;
    @(negedge clk);
    chk("rm_inrst_dmrdy", bus.dm_ready, 0);
    tick();
    rst = 0; bus.dm_req = 0;
    @(negedge clk);
    chk("rm_post_mreq", bus.mem_req, 0);
    chk("rm_post_dmrdy", bus.dm_ready, 0);
    chk("rm_post_ifrdy", bus.if_ready, 0);
    chk("rm_post_buserr", bus.bus_err, 0);
    chk("rm_post_maddr", bus.mem_addr, 0);
    tick();
    bus.mem_ack = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Runs a one-outstanding-transaction request/ack FSM toward memory and gives data accesses priority over fetch. Generates stall_if/stall_mem for the hazard logic, where they are ORed into StallF/StallD/FlushE. Discards a fetch made stale by a taken branch (PCSrcE) and bounds memory latency with a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
TIMEOUT, 255, max cycles to wait for mem_ack; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch read request; held until if_ready
if_addr  in  ADDR_W  fetch address (PCF)
if_rdata  out  DATA_W  fetched instruction; valid when if_ready
if_ready  out  1  fetch complete pulse
dm_req  in  1  data request; held until dm_ready
dm_we  in  1  1=store, 0=load
dm_addr  in  ADDR_W  data address (ALUResultM)
dm_wdata  in  DATA_W  store data
dm_be  in  DATA_W/8  store byte enables
dm_rdata  out  DATA_W  load data; valid when dm_ready
dm_ready  out  1  data access complete pulse
flush_f  in  1  taken branch/jump (PCSrcE); invalidates any in-flight fetch
mem_req  out  1  memory request; held until mem_ack
mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle completion
stall_if  out  1  to hazard logic: fetch must hold
stall_mem  out  1  to hazard logic: memory stage must hold
bus_err  out  1  sticky timeout flag

Behaviour:
- All state is registered on the rising edge of clk. rst (synchronous) sets state=IDLE and clears mem_req, mem_we, mem_addr, mem_wdata, mem_be, discard, timeout counter and bus_err. if_ready and dm_ready are 0 during reset.
- A reset in the middle of a transaction abandons it. Any mem_ack that arrives after reset in IDLE is ignored.
- FSM states: IDLE, BUSY_DM, BUSY_IF.
- IDLE, dm_req=1: latch dm_* into the mem_* registers and go to BUSY_DM.
  - dm_req has priority when dm_req and if_req are both 1.
- IDLE, dm_req=0, if_req=1, flush_f=0: latch if_addr with mem_we=0 and mem_be=all ones, then go to BUSY_IF.
- IDLE, if_req=1, flush_f=1: no fetch is launched (its PC is stale).
- mem_req=1 in every BUSY cycle and 0 in IDLE. mem_* fields stay stable for the whole transaction.
- Ack in BUSY_DM: dm_ready=1 and dm_rdata=mem_rdata in that same cycle (combinational path); next state is IDLE.
- Ack in BUSY_IF:
  - discard=0 and flush_f=0: if_ready=1 and if_rdata=mem_rdata in that same cycle; next state is IDLE.
  - Otherwise: if_ready=0 and next state is IDLE.
- Ack may arrive in the first BUSY cycle. Minimum latency is therefore request-in-IDLE plus 1 cycle.
- Throughput is at most one transaction per 2 cycles, because IDLE is always re-entered between transactions.
- discard is set by flush_f=1 in BUSY_IF and cleared on leaving BUSY_IF. The memory transaction itself always runs to completion; it is never aborted.
- Stalls:
  - stall_mem = dm_req & ~dm_ready.
  - stall_if = if_req & ~if_ready.
  - Both are combinational, so the requester advances in the ready cycle. A request still high in the next cycle is treated as a new transaction.
- A request held by a requester may only drop because of flush_f. A dm_req dropped mid-transaction is illegal (the stage is stalled).
- Timeout (TIMEOUT>0):
  - The counter clears on entry to BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT, the arbiter forces completion: the matching ready pulses with rdata=0 (if_ready still obeys discard), bus_err is set, mem_req drops, and next state is IDLE.
  - bus_err stays set until rst.
- Outside the ready cycle, if_rdata and dm_rdata are 0.

Test Plan:
- Fetch only: if_req=1 with if_addr=0x100; memory acks 2 cycles after mem_req rises with 0x00500093 -> mem_addr=0x100, mem_we=0; if_ready=1 with if_rdata=0x00500093 in the ack cycle; stall_if=1 for the 3 preceding cycles.
- Conflict: dm_req (load, addr 0x2000) and if_req (0x104) both rise in the same cycle -> data is served first (mem_addr=0x2000), then IDLE, then fetch at 0x104; stall_if stays high throughout the data transaction.
- Store: dm_we=1, dm_addr=0x2004, dm_wdata=0xDEADBEEF, dm_be=4'b0011 -> the mem_* fields match and stay stable until ack; dm_ready=1 for exactly one cycle.
- Flush in flight: flush_f=1 during BUSY_IF with addr 0x108 -> ack produces if_ready=0; the next request to 0x200 completes normally.
- Timeout with TIMEOUT=4 and no ack -> after 4 BUSY cycles: dm_ready=1 with dm_rdata=0, bus_err=1 and held; mem_req=0.
- Reset mid-transaction: rst asserted in BUSY_DM -> next cycle state is IDLE, mem_req=0; a late mem_ack produces no ready.
